// File: rtl/iz_param_loader.sv
// Byte-serial loader for the Izhikevich a/b/c/d parameters with an atomic four-word commit.
// Define IZ_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module iz_param_loader #(
  parameter logic signed [15:0] A_DEFAULT = 16'sd1,
  parameter logic signed [15:0] B_DEFAULT = 16'sd13,
  parameter logic signed [15:0] C_DEFAULT = -16'sd4160,
  parameter logic signed [15:0] D_DEFAULT = 16'sd512,
  parameter int unsigned        TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         data_in,
  input  logic               data_valid,
  output logic signed [15:0] param_a,
  output logic signed [15:0] param_b,
  output logic signed [15:0] param_c,
  output logic signed [15:0] param_d,
  output logic               params_ready,
  output logic               busy,
  output logic               load_done,
  output logic               load_error,
  output logic [3:0]         byte_count
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

`ifdef IZ_LOADER_CHECKSUM_EN
  localparam logic [3:0] LastByte = 4'd8;
`else
  localparam logic [3:0] LastByte = 4'd7;
`endif

  // Abort fires on the idle cycle that would bring the count up to TIMEOUT.
  localparam logic [15:0] IdleLimit = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  shadow_q [8];
  logic [7:0]  shadow_d [8];
  logic [3:0]  byte_count_q, byte_count_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] param_a_q, param_a_d;
  logic [15:0] param_b_q, param_b_d;
  logic [15:0] param_c_q, param_c_d;
  logic [15:0] param_d_q, param_d_d;
  logic        params_ready_q, params_ready_d;
  logic        valid_set_q, valid_set_d;
  logic        busy_q, busy_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;
  logic        frame_ok;
  logic        abort;

`ifdef IZ_LOADER_CHECKSUM_EN
  logic [7:0] shadow_xor;

  always_comb begin
    shadow_xor = 8'h00;
    for (int i = 0; i < 8; i++) begin
      shadow_xor = shadow_xor ^ shadow_q[i];
    end
  end

  assign frame_ok = (data_in == shadow_xor);
`else
  assign frame_ok = 1'b1;
`endif

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    byte_count_d   = byte_count_q;
    idle_cnt_d     = idle_cnt_q;
    param_a_d      = param_a_q;
    param_b_d      = param_b_q;
    param_c_d      = param_c_q;
    param_d_d      = param_d_q;
    params_ready_d = params_ready_q;
    valid_set_d    = valid_set_q;
    load_done_d    = 1'b0;
    load_error_d   = load_error_q;
    abort          = 1'b0;

    case (state_q)
      StIdle, StLoad: begin
        if (load_start) begin
          // Start and restart share one path; a coincident byte is dropped.
          state_d        = StLoad;
          byte_count_d   = 4'd0;
          idle_cnt_d     = 16'd0;
          load_error_d   = 1'b0;
          params_ready_d = 1'b0;
          for (int i = 0; i < 8; i++) begin
            shadow_d[i] = 8'h00;
          end
        end else if (state_q == StLoad) begin
          if (data_valid) begin
            idle_cnt_d   = 16'd0;
            byte_count_d = byte_count_q + 4'd1;
            if (!byte_count_q[3]) begin
              shadow_d[byte_count_q[2:0]] = data_in;
            end
            if (byte_count_q == LastByte) begin
              if (frame_ok) begin
                state_d = StCommit;
              end else begin
                abort = 1'b1;
              end
            end
          end else if (idle_cnt_q == IdleLimit) begin
            abort = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      StCommit: begin
        param_a_d      = {shadow_q[1], shadow_q[0]};
        param_b_d      = {shadow_q[3], shadow_q[2]};
        param_c_d      = {shadow_q[5], shadow_q[4]};
        param_d_d      = {shadow_q[7], shadow_q[6]};
        params_ready_d = 1'b1;
        valid_set_d    = 1'b1;
        load_done_d    = 1'b1;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d        = StIdle;
      load_error_d   = 1'b1;
      params_ready_d = valid_set_q;
    end
  end

  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      byte_count_q   <= 4'd0;
      idle_cnt_q     <= 16'd0;
      param_a_q      <= A_DEFAULT;
      param_b_q      <= B_DEFAULT;
      param_c_q      <= C_DEFAULT;
      param_d_q      <= D_DEFAULT;
      params_ready_q <= 1'b0;
      valid_set_q    <= 1'b0;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      load_error_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 8'h00;
      end
    end else begin
      state_q        <= state_d;
      byte_count_q   <= byte_count_d;
      idle_cnt_q     <= idle_cnt_d;
      param_a_q      <= param_a_d;
      param_b_q      <= param_b_d;
      param_c_q      <= param_c_d;
      param_d_q      <= param_d_d;
      params_ready_q <= params_ready_d;
      valid_set_q    <= valid_set_d;
      busy_q         <= busy_d;
      load_done_q    <= load_done_d;
      load_error_q   <= load_error_d;
      shadow_q       <= shadow_d;
    end
  end

  assign param_a      = param_a_q;
  assign param_b      = param_b_q;
  assign param_c      = param_c_q;
  assign param_d      = param_d_q;
  assign params_ready = params_ready_q;
  assign busy         = busy_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign byte_count   = byte_count_q;

endmodule
